// File: rtl/mac_stat_pkg.sv
// Shared definitions for the per-port MAC statistics agent:
// counter addresses, counter count and FSM state encoding.
package mac_stat_pkg;

    // Counter addresses; each counter's index in the counter array equals its address.
    localparam int ADDR_RX_FRAMES   = 0;
    localparam int ADDR_RX_BYTES    = 1;
    localparam int ADDR_RX_CRC_ERRS = 2;
    localparam int ADDR_RX_DROPS    = 3;
    localparam int ADDR_TX_FRAMES   = 4;
    localparam int ADDR_TX_BYTES    = 5;

    localparam int NUM_STAT_CNT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mac_stat_agent_if.sv
// Management bus between the SPI register controller and one MAC port agent.
// Handshake: req_valid is a single-cycle strobe with no ready/back-pressure;
// a request that arrives while busy is high is dropped. resp_valid qualifies
// resp_data for each byte of a read response, MSB first; resp_data is
// meaningless while resp_valid is low.
interface mac_stat_agent_if;
    logic       req_valid;
    logic       req_wr;
    logic [7:0] req_addr;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       busy;

    modport master (
        output req_valid, req_wr, req_addr,
        input  resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr,
        output resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mac_stat_cnt.sv
// One statistics counter: adds an arbitrary amount each cycle, clears on
// request (clear beats a same-cycle add). Build option MAC_STAT_SAT_EN makes
// the counter saturate at all-ones instead of wrapping.
module mac_stat_cnt #(
    parameter int MGNT_REG_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [MGNT_REG_WIDTH-1:0] inc,
    output logic [MGNT_REG_WIDTH-1:0] cnt,
    output logic [MGNT_REG_WIDTH-1:0] cnt_nxt
);

`ifdef MAC_STAT_SAT_EN
    logic [MGNT_REG_WIDTH:0] sum;

    // Next value with one extra bit so an overflow can be pinned to all-ones.
    always_comb begin
        sum = {1'b0, cnt} + {1'b0, inc};
        if (clr) begin
            cnt_nxt = '0;
        end else if (sum[MGNT_REG_WIDTH]) begin
            cnt_nxt = '1;
        end else begin
            cnt_nxt = sum[MGNT_REG_WIDTH-1:0];
        end
    end
`else
    // Next value, wrapping modulo 2^MGNT_REG_WIDTH.
    always_comb begin
        if (clr) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + inc;
        end
    end
`endif

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/mac_stat_agent.sv
// Per-port MAC statistics agent: six event counters, clear-by-write and
// read-by-snapshot returned as an MSB-first byte stream.
// Optional build macro: MAC_STAT_SAT_EN (saturating counters, see mac_stat_cnt).
module mac_stat_agent
    import mac_stat_pkg::*;
#(
    parameter int MGNT_REG_WIDTH = 32,
    parameter int LEN_WIDTH      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_stat_agent_if.slave      bus,
    input  logic                 rx_frame_done,
    input  logic [LEN_WIDTH-1:0] rx_len,
    input  logic                 rx_crc_err,
    input  logic                 rx_drop,
    input  logic                 tx_frame_done,
    input  logic [LEN_WIDTH-1:0] tx_len,
    output state_t               state_dbg
);

    localparam int NUM_BYTES = MGNT_REG_WIDTH / 8;
    localparam int BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);

    state_t                    state_q;
    state_t                    state_d;
    logic [MGNT_REG_WIDTH-1:0] shift_q;
    logic [BC_W-1:0]           byte_cnt_q;
    logic                      last_byte;
    logic                      load;
    logic                      clr_en;
    logic                      send;

    logic [MGNT_REG_WIDTH-1:0] inc_amt [NUM_STAT_CNT];
    logic [MGNT_REG_WIDTH-1:0] cnt     [NUM_STAT_CNT];
    logic [MGNT_REG_WIDTH-1:0] cnt_nxt [NUM_STAT_CNT];
    logic [NUM_STAT_CNT-1:0]   clr_vec;
    logic [MGNT_REG_WIDTH-1:0] rd_val;

    assign last_byte = (byte_cnt_q == LAST_BYTE);

    // Map the MAC event strobes onto per-counter increment amounts.
    always_comb begin
        inc_amt[ADDR_RX_FRAMES]   = MGNT_REG_WIDTH'(rx_frame_done);
        inc_amt[ADDR_RX_BYTES]    = rx_frame_done ? MGNT_REG_WIDTH'(rx_len) : '0;
        inc_amt[ADDR_RX_CRC_ERRS] = MGNT_REG_WIDTH'(rx_crc_err);
        inc_amt[ADDR_RX_DROPS]    = MGNT_REG_WIDTH'(rx_drop);
        inc_amt[ADDR_TX_FRAMES]   = MGNT_REG_WIDTH'(tx_frame_done);
        inc_amt[ADDR_TX_BYTES]    = tx_frame_done ? MGNT_REG_WIDTH'(tx_len) : '0;
    end

    // Clear decode: only the addressed counter; unmapped addresses clear nothing.
    always_comb begin
        for (int i = 0; i < NUM_STAT_CNT; i++) begin
            clr_vec[i] = clr_en && (bus.req_addr == 8'(i));
        end
    end

    // Read mux over post-update values so a read sees this cycle's events.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_STAT_CNT; i++) begin
            if (bus.req_addr == 8'(i)) begin
                rd_val = cnt_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_STAT_CNT; g++) begin : g_cnt
        mac_stat_cnt #(
            .MGNT_REG_WIDTH(MGNT_REG_WIDTH)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr_vec[g]),
            .inc    (inc_amt[g]),
            .cnt    (cnt[g]),
            .cnt_nxt(cnt_nxt[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a read starts a stream, the last byte ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid && !bus.req_wr) state_d = SEND;
            SEND: if (last_byte) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: requests are only acted on in IDLE.
    always_comb begin
        send   = (state_q == SEND);
        load   = (state_q == IDLE) && bus.req_valid && !bus.req_wr;
        clr_en = (state_q == IDLE) && bus.req_valid && bus.req_wr;
    end

    // Snapshot and shift; the final byte is held so resp_data keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (load) begin
            shift_q    <= rd_val;
            byte_cnt_q <= '0;
        end else if (send && !last_byte) begin
            shift_q    <= shift_q << 8;
            byte_cnt_q <= byte_cnt_q + 1'b1;
        end
    end

    assign bus.resp_valid = send;
    assign bus.busy       = send;
    assign bus.resp_data  = shift_q[MGNT_REG_WIDTH-1 -: 8];
    assign state_dbg      = state_q;

    for (genvar g = 0; g < NUM_STAT_CNT; g++) begin : g_unused
        logic unused_cnt;
        assign unused_cnt = ^cnt[g];
    end

endmodule

// File: tb/tb_mac_stat_agent.sv
// Bench for mac_stat_agent: directed scenarios plus a randomized phase,
// all outputs checked every cycle against a counter/byte-queue model.
module tb_mac_stat_agent;
    import mac_stat_pkg::*;

    localparam int W  = 32;
    localparam int LW = 11;
    localparam int NB = W / 8;
    localparam longint unsigned MAXV = (64'd1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_stat_agent_if bus();

    logic          rx_frame_done = 1'b0;
    logic [LW-1:0] rx_len        = '0;
    logic          rx_crc_err    = 1'b0;
    logic          rx_drop       = 1'b0;
    logic          tx_frame_done = 1'b0;
    logic [LW-1:0] tx_len        = '0;
    state_t        state_dbg;

    mac_stat_agent #(.MGNT_REG_WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rx_frame_done(rx_frame_done),
        .rx_len       (rx_len),
        .rx_crc_err   (rx_crc_err),
        .rx_drop      (rx_drop),
        .tx_frame_done(tx_frame_done),
        .tx_len       (tx_len),
        .state_dbg    (state_dbg)
    );

    // ---------------- reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned m_cnt [NUM_STAT_CNT];
    logic [7:0]      exp_q [$];
    logic [7:0]      last_byte = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned add_amt(input longint unsigned v, input longint unsigned a);
        longint unsigned s;
        s = v + a;
        if (s > MAXV) begin
`ifdef MAC_STAT_SAT_EN
            s = MAXV;
`else
            s = s - (MAXV + 1);
`endif
        end
        return s;
    endfunction

    // Outputs expected in the current cycle, from the model's byte queue.
    task automatic check_outputs();
        if (exp_q.size() != 0) begin
            chk("resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("busy", 64'(bus.busy), 64'd1);
            chk("resp_data", 64'(bus.resp_data), 64'(exp_q[0]));
        end else begin
            chk("resp_valid_idle", 64'(bus.resp_valid), 64'd0);
            chk("busy_idle", 64'(bus.busy), 64'd0);
            chk("resp_data_hold", 64'(bus.resp_data), 64'(last_byte));
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then check.
    task automatic tick();
        logic            busy_m;
        longint unsigned snap;
        int              a;
        @(posedge clk);
        busy_m = (exp_q.size() != 0);
        if (!rst) begin
            for (int i = 0; i < NUM_STAT_CNT; i++) m_cnt[i] = 0;
            exp_q.delete();
            last_byte = 8'h00;
        end else begin
            if (busy_m) last_byte = exp_q.pop_front();
            if (rx_frame_done) begin
                m_cnt[0] = add_amt(m_cnt[0], 1);
                m_cnt[1] = add_amt(m_cnt[1], longint'(rx_len));
            end
            if (rx_crc_err) m_cnt[2] = add_amt(m_cnt[2], 1);
            if (rx_drop)    m_cnt[3] = add_amt(m_cnt[3], 1);
            if (tx_frame_done) begin
                m_cnt[4] = add_amt(m_cnt[4], 1);
                m_cnt[5] = add_amt(m_cnt[5], longint'(tx_len));
            end
            if (bus.req_valid && !busy_m) begin
                a = int'(bus.req_addr);
                if (bus.req_wr) begin
                    if (a < NUM_STAT_CNT) m_cnt[a] = 0;
                end else begin
                    snap = (a < NUM_STAT_CNT) ? m_cnt[a] : 0;
                    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(8'(snap >> (8 * i)));
                end
            end
        end
        #1;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_events();
        rx_frame_done = 1'b0;
        rx_crc_err    = 1'b0;
        rx_drop       = 1'b0;
        tx_frame_done = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [7:0] addr);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
    endtask

    task automatic read_val(input logic [7:0] addr, output logic [W-1:0] val);
        do_req(1'b0, addr);
        val = '0;
        for (int i = 0; i < NB; i++) begin
            val = {val[W-9:0], bus.resp_data};
            tick();
        end
    endtask

    logic [W-1:0] got;
    int           vcnt;
    longint unsigned saved [NUM_STAT_CNT];

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 8'h00;
        for (int i = 0; i < NUM_STAT_CNT; i++) m_cnt[i] = 0;

        // Reset
        rst = 1'b0;
        repeat (3) tick();
        chk("reset_resp_data", 64'(bus.resp_data), 64'd0);
        rst = 1'b1;
        tick();

        // Three received frames, then byte and frame counts
        rx_frame_done = 1'b1;
        rx_len = 11'd64;   tick();
        rx_len = 11'd1518; tick();
        rx_len = 11'd100;  tick();
        clear_events();
        read_val(8'h01, got);
        chk("rx_bytes_1682", 64'(got), 64'h0000_0692);
        read_val(8'h00, got);
        chk("rx_frames_3", 64'(got), 64'd3);

        // Clear beats same-cycle increment; other counters still count
        rx_frame_done = 1'b1;
        rx_len        = 11'd200;
        rx_crc_err    = 1'b1;
        do_req(1'b1, 8'h00);
        clear_events();
        read_val(8'h00, got);
        chk("rx_frames_cleared", 64'(got), 64'd0);
        read_val(8'h02, got);
        chk("crc_err_1", 64'(got), 64'd1);
        read_val(8'h01, got);
        chk("rx_bytes_1882", 64'(got), 64'd1882);

        // Read at T, second read at T+2 is ignored
        tx_frame_done = 1'b1;
        tx_len        = 11'd60;
        tick();
        clear_events();
        vcnt = 0;
        do_req(1'b0, 8'h04);
        vcnt += bus.resp_valid ? 1 : 0;
        tick();
        vcnt += bus.resp_valid ? 1 : 0;
        do_req(1'b0, 8'h05);
        vcnt += bus.resp_valid ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vcnt += bus.resp_valid ? 1 : 0;
        end
        chk("single_burst_len", 64'(vcnt), 64'(NB));

        // Unmapped address: zero read, no-op clear
        read_val(8'h7F, got);
        chk("unmapped_read", 64'(got), 64'd0);
        for (int i = 0; i < NUM_STAT_CNT; i++) saved[i] = m_cnt[i];
        do_req(1'b1, 8'h7F);
        for (int i = 0; i < NUM_STAT_CNT; i++) begin
            read_val(8'(i), got);
            chk("unmapped_clear_keep", 64'(got), 64'(saved[i]));
        end

        // Randomized events and requests
        for (int c = 0; c < 400; c++) begin
            rx_frame_done = ($urandom_range(0, 3) == 0);
            rx_len        = LW'($urandom_range(0, 2047));
            rx_crc_err    = ($urandom_range(0, 5) == 0);
            rx_drop       = ($urandom_range(0, 5) == 0);
            tx_frame_done = ($urandom_range(0, 3) == 0);
            tx_len        = LW'($urandom_range(0, 2047));
            bus.req_valid = ($urandom_range(0, 5) == 0);
            bus.req_wr    = ($urandom_range(0, 4) == 0);
            bus.req_addr  = ($urandom_range(0, 9) == 0) ? 8'h7F : 8'($urandom_range(0, 7));
            tick();
        end
        clear_events();
        bus.req_valid = 1'b0;
        repeat (NB + 1) tick();
        for (int i = 0; i < NUM_STAT_CNT; i++) begin
            saved[i] = m_cnt[i];
            read_val(8'(i), got);
            chk("random_final", 64'(got), 64'(saved[i]));
        end

        // tx_frames at all-ones, then one more frame
        force dut.g_cnt[4].u_cnt.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.g_cnt[4].u_cnt.cnt;
        m_cnt[4] = MAXV;
        tx_frame_done = 1'b1;
        tx_len        = 11'd0;
        tick();
        clear_events();
        read_val(8'h04, got);
`ifdef MAC_STAT_SAT_EN
        chk("tx_frames_sat", 64'(got), 64'hFFFF_FFFF);
`else
        chk("tx_frames_wrap", 64'(got), 64'h0);
`endif

        // Reset in the middle of a response stream
        do_req(1'b0, 8'h01);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_drops_valid", 64'(bus.resp_valid), 64'd0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < NUM_STAT_CNT; i++) begin
            read_val(8'(i), got);
            chk("post_reset_zero", 64'(got), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
